pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards, freezes the pipe
//  while data memory is busy, squashes wrong-path instructions on EX redirect (branch/jal/jalr), and
//  latches halt on retired break/trap. Generates IF/ID and ID/EX hold/flush controls and forwarding selects.
// PARAMETERS
//  REG_AW        5   register address width
//  LOAD_BUBBLES  1   stall cycles inserted per load-use hazard (legal 1..3)
//  CNT_W         32  width of perf counters (PIPE_CTRL_PERF_EN only)
// PORTS
//  i_clk           in   1       global clock
//  i_rst           in   1       reset, asynchronous, active-high
//  i_id_rs1_raddr  in   REG_AW  rs1 of instruction in ID;   i_id_rs1_used in 1: rs1 is read
//  i_id_rs2_raddr  in   REG_AW  rs2 of instruction in ID;   i_id_rs2_used in 1: rs2 is read
//  i_ex_rd_waddr   in   REG_AW  rd in EX;   i_ex_rd_wen in 1;   i_ex_mem_read in 1: EX is a load
//  i_mem_rd_waddr  in   REG_AW  rd in MEM;  i_mem_rd_wen in 1
//  i_ex_redirect   in   1       EX resolved taken branch/jump (valid instr only)
//  i_dmem_busy     in   1       data memory access not complete this cycle
//  i_halt          in   1       break/trap retired in WB
//  o_if_hold       out  1       hold PC / fetch
//  o_if_id_hold    out  1       hold IF/ID register
//  o_id_ex_hold    out  1       hold ID/EX register
//  o_if_id_flush   out  1       load bubble (vld=0) into IF/ID
//  o_id_ex_flush   out  1       load bubble (vld=0) into ID/EX
//  o_frwd_alu_op1/op2  out 1    forward EX result to op1/op2;  o_frwd_mem_op1/op2 out 1: forward MEM result
//  o_state         out  3       current FSM state (debug)
//  o_halted        out  1       pipeline halted
// BEHAVIOUR
//  - States: RUN=0, LSTALL=1, MWAIT=2, FLUSH=3, HALT=4. Reset (async): state=RUN, bubble cnt=0,
//    pend_redirect=0; all outputs 0 except as decoded from RUN with current inputs.
//  - Outputs are combinational from state + inputs; state/counters registered. Zero-cycle decision latency.
//  - Priority each cycle: i_halt > i_dmem_busy > redirect (live or pending) > load-use > run.
//  - hazard = i_ex_mem_read & i_ex_rd_wen & rd!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
//  - RUN: hazard -> o_if_hold=o_if_id_hold=1, o_id_ex_flush=1, cnt=LOAD_BUBBLES-1, go LSTALL
//    (or stay RUN if LOAD_BUBBLES==1). Redirect -> o_if_id_flush=o_id_ex_flush=1, go FLUSH.
//  - LSTALL: keep IF/IF-ID hold + ID/EX flush; cnt decrements; cnt==0 -> RUN.
//  - MWAIT (entered from any non-HALT state while i_dmem_busy): all three holds=1, no flush; a redirect
//    seen while busy sets pend_redirect. Exit when !busy: pend_redirect -> flush both, go FLUSH, clear pend;
//    else return to saved state (LSTALL resumes with cnt unchanged).
//  - FLUSH: one cycle, o_if_id_flush=1 (fetch at target arrives next), then RUN.
//  - Redirect + hazard same cycle: redirect wins, load-use ignored (consumer squashed).
//  - HALT: i_halt in any state -> HALT next; sticky until reset; all holds=1, o_halted=1.
//  - Hold and flush on same register never both 1; flush wins if decode would give both.
//  - Forwarding: alu_opN = EX rd_wen & rd!=0 & rd==rsN & !ex_mem_read; mem_opN = MEM rd_wen & rd!=0 &
//    rd==rsN & !alu_opN. x0 never forwarded. Forward outputs forced 0 in HALT.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds o_stall_cycles, o_flush_count (CNT_W, saturating, reset 0):
//    stall_cycles +1 per cycle any hold=1 outside HALT; flush_count +1 per FLUSH entry.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  Shared package pipe_pkg: state encoding constants, REG_AW default, LOAD_BUBBLES limits.
//  Sub-module pipe_fwd: purely combinational forwarding/hazard compare; FSM lives in pipe_ctrl.
// TESTING
//  lw x5 in EX, ID add x6,x5,x1 -> o_if_hold=o_if_id_hold=o_id_ex_flush=1 for exactly LOAD_BUBBLES cycles.
//  lw x0 in EX, ID reads x0 -> no stall, no forward.
//  add x7 in EX and MEM both writing x7, ID reads x7 -> o_frwd_alu_op1=1, o_frwd_mem_op1=0.
//  i_ex_redirect with hazard same cycle -> both flushes=1, state FLUSH, no LSTALL.
//  i_dmem_busy 3 cycles with redirect in cycle 2 -> 3 cycles full hold, then flush, FLUSH, RUN.
//  i_halt in LSTALL -> HALT sticky; async i_rst mid-cycle -> state RUN, counters 0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding and size limits.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int LB_MIN     = 1;
  localparam int LB_MAX     = 3;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_LSTALL = 3'd1,
    ST_MWAIT  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_HALT   = 3'd4
  } pipe_state_t;

endpackage

// File: rtl/pipe_fwd.sv
// Combinational operand forwarding selects and load-use hazard compare for the instruction in ID.
module pipe_fwd
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_rs1,
  input  logic              i_rs1_used,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_wen,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_wen,
  output logic              o_alu_op1,
  output logic              o_alu_op2,
  output logic              o_mem_op1,
  output logic              o_mem_op2,
  output logic              o_hazard
);

  logic w_ex_wr, w_mem_wr;

  // x0 is hardwired zero, so writes to it never produce a dependency.
  assign w_ex_wr  = i_ex_wen  & (i_ex_rd  != '0);
  assign w_mem_wr = i_mem_wen & (i_mem_rd != '0);

  assign o_alu_op1 = w_ex_wr & (i_ex_rd == i_rs1) & ~i_ex_mem_read;
  assign o_alu_op2 = w_ex_wr & (i_ex_rd == i_rs2) & ~i_ex_mem_read;
  assign o_mem_op1 = w_mem_wr & (i_mem_rd == i_rs1) & ~o_alu_op1;
  assign o_mem_op2 = w_mem_wr & (i_mem_rd == i_rs2) & ~o_alu_op2;

  assign o_hazard = i_ex_mem_read & w_ex_wr &
                    ((i_rs1_used & (i_rs1 == i_ex_rd)) | (i_rs2_used & (i_rs2 == i_ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs decode combinationally from state + inputs.
// Optional PIPE_CTRL_PERF_EN adds saturating stall-cycle and flush-entry counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_id_rs1_raddr,
  input  logic              i_id_rs1_used,
  input  logic [REG_AW-1:0] i_id_rs2_raddr,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rd_waddr,
  input  logic              i_ex_rd_wen,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_mem_rd_waddr,
  input  logic              i_mem_rd_wen,
  input  logic              i_ex_redirect,
  input  logic              i_dmem_busy,
  input  logic              i_halt,
  output logic              o_if_hold,
  output logic              o_if_id_hold,
  output logic              o_id_ex_hold,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_frwd_alu_op1,
  output logic              o_frwd_alu_op2,
  output logic              o_frwd_mem_op1,
  output logic              o_frwd_mem_op2,
  output logic [2:0]        o_state,
  output logic              o_halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic [CNT_W-1:0]  o_flush_count
`endif
);

  localparam logic [1:0] LB_INIT = 2'(LOAD_BUBBLES - 1);

  // Out-of-range configurations elaborate this marker block so they show up in the hierarchy.
  if (LOAD_BUBBLES < LB_MIN || LOAD_BUBBLES > LB_MAX || CNT_W < 1) begin : g_bad_cfg
  end

  pipe_state_t r_state, r_saved;
  logic [1:0]  r_cnt;
  logic        r_pend;

  pipe_state_t w_nxt, w_saved_nxt, w_eff;
  logic [1:0]  w_cnt_nxt;
  logic        w_pend_nxt, w_redir, w_hazard;
  logic        w_if_hold, w_if_id_hold, w_id_ex_hold, w_if_id_flush, w_id_ex_flush;
  logic        w_alu1, w_alu2, w_mem1, w_mem2;

  pipe_fwd #(.REG_AW(REG_AW)) u_fwd (
    .i_rs1         (i_id_rs1_raddr),
    .i_rs1_used    (i_id_rs1_used),
    .i_rs2         (i_id_rs2_raddr),
    .i_rs2_used    (i_id_rs2_used),
    .i_ex_rd       (i_ex_rd_waddr),
    .i_ex_wen      (i_ex_rd_wen),
    .i_ex_mem_read (i_ex_mem_read),
    .i_mem_rd      (i_mem_rd_waddr),
    .i_mem_wen     (i_mem_rd_wen),
    .o_alu_op1     (w_alu1),
    .o_alu_op2     (w_alu2),
    .o_mem_op1     (w_mem1),
    .o_mem_op2     (w_mem2),
    .o_hazard      (w_hazard)
  );

  // Leaving MWAIT decodes as the interrupted state, so a load stall resumes seamlessly.
  assign w_eff   = (r_state == ST_MWAIT) ? r_saved : r_state;
  assign w_redir = i_ex_redirect | r_pend;

  always_comb begin
    w_nxt         = r_state;
    w_saved_nxt   = r_saved;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_if_hold     = 1'b0;
    w_if_id_hold  = 1'b0;
    w_id_ex_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (r_state == ST_HALT || i_halt) begin
      w_if_hold    = 1'b1;
      w_if_id_hold = 1'b1;
      w_id_ex_hold = 1'b1;
      w_nxt        = ST_HALT;
    end else if (i_dmem_busy) begin
      w_if_hold    = 1'b1;
      w_if_id_hold = 1'b1;
      w_id_ex_hold = 1'b1;
      w_nxt        = ST_MWAIT;
      if (r_state != ST_MWAIT) w_saved_nxt = r_state;
      if (i_ex_redirect)       w_pend_nxt  = 1'b1;
    end else if (w_redir) begin
      // Redirect beats load-use: the dependent instruction is on the wrong path anyway.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_pend_nxt    = 1'b0;
      w_nxt         = ST_FLUSH;
    end else begin
      case (w_eff)
        ST_RUN: begin
          w_nxt = ST_RUN;
          if (w_hazard) begin
            w_if_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_id_ex_flush = 1'b1;
            w_cnt_nxt     = LB_INIT;
            if (LOAD_BUBBLES > 1) w_nxt = ST_LSTALL;
          end
        end
        ST_LSTALL: begin
          w_if_hold     = 1'b1;
          w_if_id_hold  = 1'b1;
          w_id_ex_flush = 1'b1;
          w_cnt_nxt     = r_cnt - 2'd1;
          w_nxt         = (w_cnt_nxt == 2'd0) ? ST_RUN : ST_LSTALL;
        end
        ST_FLUSH: begin
          w_if_id_flush = 1'b1;
          w_nxt         = ST_RUN;
        end
        default: w_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
      r_cnt   <= 2'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign o_if_hold      = w_if_hold;
  assign o_if_id_hold   = w_if_id_hold & ~w_if_id_flush;
  assign o_id_ex_hold   = w_id_ex_hold & ~w_id_ex_flush;
  assign o_if_id_flush  = w_if_id_flush;
  assign o_id_ex_flush  = w_id_ex_flush;
  assign o_halted       = (r_state == ST_HALT);
  assign o_state        = r_state;
  assign o_frwd_alu_op1 = w_alu1 & ~o_halted;
  assign o_frwd_alu_op2 = w_alu2 & ~o_halted;
  assign o_frwd_mem_op1 = w_mem1 & ~o_halted;
  assign o_frwd_mem_op2 = w_mem2 & ~o_halted;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
  logic             w_any_hold;

  assign w_any_hold = o_if_hold | o_if_id_hold | o_id_ex_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_any_hold && r_state != ST_HALT && r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_nxt == ST_FLUSH && r_state != ST_FLUSH && r_flush_count != '1)
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with LOAD_BUBBLES=2; expected values are hand-computed per vector.
module tb_pipe_ctrl;
  localparam int AW = 5;
  localparam int LB = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_id_rs1_raddr, i_id_rs2_raddr, i_ex_rd_waddr, i_mem_rd_waddr;
  logic          i_id_rs1_used, i_id_rs2_used, i_ex_rd_wen, i_ex_mem_read, i_mem_rd_wen;
  logic          i_ex_redirect, i_dmem_busy, i_halt;
  logic          o_if_hold, o_if_id_hold, o_id_ex_hold, o_if_id_flush, o_id_ex_flush;
  logic          o_frwd_alu_op1, o_frwd_alu_op2, o_frwd_mem_op1, o_frwd_mem_op2;
  logic [2:0]    o_state;
  logic          o_halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   o_stall_cycles, o_flush_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(LB), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs1_raddr(i_id_rs1_raddr), .i_id_rs1_used(i_id_rs1_used),
    .i_id_rs2_raddr(i_id_rs2_raddr), .i_id_rs2_used(i_id_rs2_used),
    .i_ex_rd_waddr(i_ex_rd_waddr), .i_ex_rd_wen(i_ex_rd_wen), .i_ex_mem_read(i_ex_mem_read),
    .i_mem_rd_waddr(i_mem_rd_waddr), .i_mem_rd_wen(i_mem_rd_wen),
    .i_ex_redirect(i_ex_redirect), .i_dmem_busy(i_dmem_busy), .i_halt(i_halt),
    .o_if_hold(o_if_hold), .o_if_id_hold(o_if_id_hold), .o_id_ex_hold(o_id_ex_hold),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_frwd_alu_op1(o_frwd_alu_op1), .o_frwd_alu_op2(o_frwd_alu_op2),
    .o_frwd_mem_op1(o_frwd_mem_op1), .o_frwd_mem_op2(o_frwd_mem_op2),
    .o_state(o_state), .o_halted(o_halted)
`ifdef PIPE_CTRL_PERF_EN
    , .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // {if_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush}
  logic [4:0] ctl;
  logic [3:0] fwd;
  assign ctl = {o_if_hold, o_if_id_hold, o_id_ex_hold, o_if_id_flush, o_id_ex_flush};
  assign fwd = {o_frwd_alu_op1, o_frwd_alu_op2, o_frwd_mem_op1, o_frwd_mem_op2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_id_rs1_raddr = '0; i_id_rs1_used = 1'b0;
    i_id_rs2_raddr = '0; i_id_rs2_used = 1'b0;
    i_ex_rd_waddr  = '0; i_ex_rd_wen   = 1'b0; i_ex_mem_read = 1'b0;
    i_mem_rd_waddr = '0; i_mem_rd_wen  = 1'b0;
    i_ex_redirect  = 1'b0; i_dmem_busy = 1'b0; i_halt = 1'b0;
  endtask

  // lw x5 in EX, ID: add x6,x5,x1
  task automatic load_use();
    idle();
    i_ex_rd_waddr = 5'd5; i_ex_rd_wen = 1'b1; i_ex_mem_read = 1'b1;
    i_id_rs1_raddr = 5'd5; i_id_rs1_used = 1'b1;
    i_id_rs2_raddr = 5'd1; i_id_rs2_used = 1'b1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    tick(); tick();
    i_rst = 1'b0;

    // load-use: two stall cycles, then released
    load_use(); #1;
    chk("lu0_ctl", 32'(ctl), 32'b11001);
    chk("lu0_fwd", 32'(fwd), 32'b0000);
    tick();
    idle();
    i_mem_rd_waddr = 5'd5; i_mem_rd_wen = 1'b1;
    i_id_rs1_raddr = 5'd5; i_id_rs1_used = 1'b1; #1;
    chk("lu1_state", 32'(o_state), 32'd1);
    chk("lu1_ctl", 32'(ctl), 32'b11001);
    chk("lu1_fwd_mem", 32'(fwd), 32'b0010);
    tick();
    idle(); #1;
    chk("lu2_state", 32'(o_state), 32'd0);
    chk("lu2_ctl", 32'(ctl), 32'b00000);

    // unused rs2 matching a load rd is not a hazard
    idle();
    i_ex_rd_waddr = 5'd9; i_ex_rd_wen = 1'b1; i_ex_mem_read = 1'b1;
    i_id_rs2_raddr = 5'd9; i_id_rs2_used = 1'b0; #1;
    chk("rs2_unused_ctl", 32'(ctl), 32'b00000);
    tick();
    chk("rs2_unused_state", 32'(o_state), 32'd0);

    // lw x0 with ID reading x0: no stall, no forward
    idle();
    i_ex_rd_waddr = 5'd0; i_ex_rd_wen = 1'b1; i_ex_mem_read = 1'b1;
    i_mem_rd_waddr = 5'd0; i_mem_rd_wen = 1'b1;
    i_id_rs1_used = 1'b1; i_id_rs2_used = 1'b1; #1;
    chk("x0_ctl", 32'(ctl), 32'b00000);
    chk("x0_fwd", 32'(fwd), 32'b0000);

    // x7 in EX and MEM, ID reads x7: EX result wins
    idle();
    i_ex_rd_waddr = 5'd7; i_ex_rd_wen = 1'b1;
    i_mem_rd_waddr = 5'd7; i_mem_rd_wen = 1'b1;
    i_id_rs1_raddr = 5'd7; i_id_rs1_used = 1'b1;
    i_id_rs2_raddr = 5'd3; i_id_rs2_used = 1'b1; #1;
    chk("fwd_ex_mem_x7", 32'(fwd), 32'b1000);
    i_mem_rd_waddr = 5'd3; #1;
    chk("fwd_split", 32'(fwd), 32'b1001);
    chk("fwd_ctl", 32'(ctl), 32'b00000);
    tick();

    // redirect together with hazard: flush, no load stall
    load_use(); i_ex_redirect = 1'b1; #1;
    chk("rd_hz_ctl", 32'(ctl), 32'b00011);
    tick();
    idle(); #1;
    chk("rd_hz_state", 32'(o_state), 32'd3);
    chk("flush_ctl", 32'(ctl), 32'b00010);
    tick();
    chk("flush_done", 32'(o_state), 32'd0);

    // dmem busy for 3 cycles, redirect during the 2nd
    idle(); i_dmem_busy = 1'b1; #1;
    chk("busy1_ctl", 32'(ctl), 32'b11100);
    tick();
    i_ex_redirect = 1'b1; #1;
    chk("busy2_state", 32'(o_state), 32'd2);
    chk("busy2_ctl", 32'(ctl), 32'b11100);
    tick();
    i_ex_redirect = 1'b0; #1;
    chk("busy3_ctl", 32'(ctl), 32'b11100);
    tick();
    i_dmem_busy = 1'b0; #1;
    chk("busy_exit_ctl", 32'(ctl), 32'b00011);
    chk("busy_exit_state", 32'(o_state), 32'd2);
    tick();
    chk("busy_flush_state", 32'(o_state), 32'd3);
    chk("busy_flush_ctl", 32'(ctl), 32'b00010);
    tick();
    chk("busy_run_state", 32'(o_state), 32'd0);

    // busy during a load stall: stall resumes with the remaining count
    load_use(); tick();
    idle(); i_dmem_busy = 1'b1; #1;
    chk("ls_busy_ctl", 32'(ctl), 32'b11100);
    tick();
    i_dmem_busy = 1'b0; #1;
    chk("ls_resume_ctl", 32'(ctl), 32'b11001);
    tick();
    chk("ls_resume_run", 32'(o_state), 32'd0);

    // halt while in LSTALL is sticky and kills forwarding
    load_use(); tick();
    chk("halt_pre_state", 32'(o_state), 32'd1);
    idle(); i_halt = 1'b1; tick();
    i_halt = 1'b0;
    i_ex_rd_waddr = 5'd7; i_ex_rd_wen = 1'b1;
    i_id_rs1_raddr = 5'd7; i_id_rs1_used = 1'b1; #1;
    chk("halt_state", 32'(o_state), 32'd4);
    chk("halt_flag", 32'(o_halted), 32'd1);
    chk("halt_ctl", 32'(ctl), 32'b11100);
    chk("halt_fwd", 32'(fwd), 32'b0000);
    i_ex_redirect = 1'b1; i_dmem_busy = 1'b1;
    tick(); tick();
    chk("halt_sticky", 32'(o_state), 32'd4);

    // async reset mid-cycle takes effect without a clock edge
    idle();
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(o_state), 32'd0);
    chk("async_rst_halted", 32'(o_halted), 32'd0);
    tick();
    i_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
